// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UartTxEn between NREQ byte streams.
// Optional macro UART_TX_ARB_PRIORITY_EN makes requester 0 high priority at grant boundaries.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    use_flow_control,
    input  logic                    cts,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    active
);

    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t          state_r;
    logic [NREQ-1:0] req_ready_r;
    logic            tx_valid_r;
    logic [7:0]      tx_data_r;
    logic [GW-1:0]   grant_id_r;
    logic            active_r;
    logic [GW-1:0]   rr_ptr_r;
    logic [7:0]      burst_cnt_r;
    logic            last_q_r;

    logic [GW-1:0]   winner_s;
    logic            any_s;
    logic [GW-1:0]   cand_s;
    logic            hit_s;
    logic [7:0]      lane_s;
    logic            cts_ok_s;

    // Pointer handed to the next arbitration after a grant is released.
    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
        logic [GW-1:0] n;
        if (int'(g) == NREQ - 1) begin
            n = {GW{1'b0}};
        end else begin
            n = g + {{(GW-1){1'b0}}, 1'b1};
        end
`ifdef UART_TX_ARB_PRIORITY_EN
        // Requester 0 never takes part in the rotation, so the pointer skips it.
        n = (n == {GW{1'b0}}) ? {{(GW-1){1'b0}}, 1'b1} : n;
`endif
        return n;
    endfunction

    // Winner selection: first valid requester scanning upward from rr_ptr_r.
    always_comb begin
        winner_s = {GW{1'b0}};
        any_s    = 1'b0;
        cand_s   = {GW{1'b0}};
        hit_s    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = GW'((int'(rr_ptr_r) + k) % NREQ);
            hit_s  = req_valid[cand_s] & ~any_s;
`ifdef UART_TX_ARB_PRIORITY_EN
            hit_s  = hit_s & (cand_s != {GW{1'b0}});
`endif
            winner_s = hit_s ? cand_s : winner_s;
            any_s    = any_s | hit_s;
        end
`ifdef UART_TX_ARB_PRIORITY_EN
        winner_s = req_valid[0] ? {GW{1'b0}} : winner_s;
        any_s    = any_s | req_valid[0];
`endif
    end

    // Granted lane byte and the launch permission from flow control.
    always_comb begin
        lane_s   = req_data[{grant_id_r, 3'b000} +: 8];
        cts_ok_s = cts | ~use_flow_control;
    end

    // Arbitration / byte sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r     <= ST_IDLE;
            req_ready_r <= {NREQ{1'b0}};
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            grant_id_r  <= {GW{1'b0}};
            active_r    <= 1'b0;
            rr_ptr_r    <= {GW{1'b0}};
            burst_cnt_r <= 8'd0;
            last_q_r    <= 1'b0;
        end else begin
            tx_valid_r  <= 1'b0;
            req_ready_r <= {NREQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        grant_id_r  <= winner_s;
                        active_r    <= 1'b1;
                        burst_cnt_r <= 8'd0;
                        state_r     <= ST_LAUNCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    if (!req_valid[grant_id_r]) begin
                        // A stalled requester forfeits the rest of its packet slot.
                        active_r <= 1'b0;
                        rr_ptr_r <= next_ptr(grant_id_r);
                        state_r  <= ST_IDLE;
                    end else if (cts_ok_s && !tx_busy) begin
                        tx_valid_r  <= 1'b1;
                        tx_data_r   <= lane_s;
                        req_ready_r <= {{(NREQ-1){1'b0}}, 1'b1} << grant_id_r;
                        last_q_r    <= req_last[grant_id_r];
                        burst_cnt_r <= burst_cnt_r + 8'd1;
                        state_r     <= ST_WAIT;
                    end else begin
                        state_r <= ST_LAUNCH;
                    end
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (last_q_r || (burst_cnt_r == 8'(MAX_BURST))) begin
                            active_r <= 1'b0;
                            rr_ptr_r <= next_ptr(grant_id_r);
                            state_r  <= ST_IDLE;
                        end else begin
                            state_r <= ST_LAUNCH;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    active_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign tx_valid  = tx_valid_r;
    assign tx_data   = tx_data_r;
    assign grant_id  = grant_id_r;
    assign active    = active_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; models UartTxEn as 10 busy cycles then a tx_done pulse.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        nReset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        use_flow_control;
    logic        cts;
    logic        tx_busy;
    logic        tx_done;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [1:0]  grant_id;
    logic        active;

    int total = 0;
    int bad   = 0;
    int bcnt;

    uart_tx_arbiter #(.NREQ(4), .MAX_BURST(4)) dut (
        .clk(clk), .nReset(nReset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .use_flow_control(use_flow_control),
        .cts(cts), .tx_busy(tx_busy), .tx_done(tx_done), .tx_data(tx_data),
        .tx_valid(tx_valid), .grant_id(grant_id), .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UartTxEn stand-in
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        bcnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (!nReset) begin
                tx_busy = 1'b0;
                bcnt    = 0;
            end else if (tx_valid) begin
                tx_busy = 1'b1;
                bcnt    = 10;
            end else if (tx_busy) begin
                bcnt = bcnt - 1;
                if (bcnt == 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_launch(input string tag, input int budget);
        int n = 0;
        tick();
        while (!tx_valid && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_launch_seen"}, {31'd0, tx_valid}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (active && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, {31'd0, active}, 32'd0);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        tick();
        tick();
        nReset = 1'b1;
        tick();
    endtask

    logic [1:0] rr_gnt  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] rr_dat  [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    logic [1:0] bu_gnt  [9] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [7:0] bu_dat  [9] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'hC3, 8'h54, 8'h55, 8'h56, 8'h57};

    initial begin
        int seen;
        int n;
        nReset = 1'b0;
        req_valid = 4'b0000;
        req_data = 32'h0000_0000;
        req_last = 4'b0000;
        use_flow_control = 1'b0;
        cts = 1'b1;
        tick();
        tick();
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        nReset = 1'b1;
        tick();

        // Single requester, two-byte packet
        req_valid = 4'b0010;
        req_data[15:8] = 8'hA5;
        req_last = 4'b0000;
        wait_launch("single1", 40);
        chk("single1_data", {24'd0, tx_data}, 32'h0000_00A5);
        chk("single1_ready", {28'd0, req_ready}, 32'h2);
        chk("single1_gnt", {30'd0, grant_id}, 32'd1);
        chk("single1_active", {31'd0, active}, 32'd1);
        req_data[15:8] = 8'h3C;
        req_last = 4'b0010;
        tick();
        chk("single_ready_pulse", {28'd0, req_ready}, 32'h0);
        wait_launch("single2", 40);
        chk("single2_data", {24'd0, tx_data}, 32'h0000_003C);
        chk("single2_ready", {28'd0, req_ready}, 32'h2);
        req_valid = 4'b0000;
        req_last = 4'b0000;
        n = 0;
        tick();
        while (!tx_done && n < 30) begin
            chk("single_no_early_valid", {31'd0, tx_valid}, 32'd0);
            tick();
            n++;
        end
        chk("single_done_seen", {31'd0, tx_done}, 32'd1);
        chk("single_active_held", {31'd0, active}, 32'd1);
        tick();
        chk("single_active_drop", {31'd0, active}, 32'd0);
        chk("single_rr_ptr", {30'd0, dut.rr_ptr_r}, 32'd2);
        chk("single_gnt_kept", {30'd0, grant_id}, 32'd1);

`ifndef UART_TX_ARB_PRIORITY_EN
        // Round-robin with one-byte packets from everyone
        do_reset();
        req_data = 32'h4332_2110;
        req_last = 4'b1111;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_launch("rr", 40);
            chk("rr_gnt", {30'd0, grant_id}, {30'd0, rr_gnt[i]});
            chk("rr_data", {24'd0, tx_data}, {24'd0, rr_dat[i]});
            chk("rr_ready", {28'd0, req_ready}, 32'd1 << rr_gnt[i]);
        end
        req_valid = 4'b0000;
        wait_idle("rr", 40);
`endif

        // Burst cap of 4 bytes
        do_reset();
        req_data = 32'hC350_0000;
        req_last = 4'b1000;
        req_valid = 4'b1100;
        for (int i = 0; i < 9; i++) begin
            wait_launch("burst", 40);
            chk("burst_gnt", {30'd0, grant_id}, {30'd0, bu_gnt[i]});
            chk("burst_data", {24'd0, tx_data}, {24'd0, bu_dat[i]});
            if (req_ready[2]) req_data[23:16] = req_data[23:16] + 8'd1;
            if (req_ready[3]) req_valid[3] = 1'b0;
        end
        req_valid = 4'b0000;
        wait_idle("burst", 60);

        // Flow control holds launches while cts is low
        do_reset();
        use_flow_control = 1'b1;
        cts = 1'b0;
        req_data = 32'h0000_0077;
        req_last = 4'b0001;
        req_valid = 4'b0001;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_valid) seen++;
        end
        chk("fc_hold", seen, 32'd0);
        cts = 1'b1;
        tick();
        chk("fc_release_valid", {31'd0, tx_valid}, 32'd1);
        chk("fc_release_data", {24'd0, tx_data}, 32'h77);
        req_valid = 4'b0000;
        wait_idle("fc", 40);
        use_flow_control = 1'b0;
        cts = 1'b0;
        req_data = 32'h0000_0088;
        req_valid = 4'b0001;
        wait_launch("nofc", 20);
        chk("nofc_data", {24'd0, tx_data}, 32'h88);
        req_valid = 4'b0000;
        wait_idle("nofc", 40);
        cts = 1'b1;

        // Asynchronous reset while waiting for tx_done
        req_data = 32'h0000_9900;
        req_last = 4'b0010;
        req_valid = 4'b0010;
        wait_launch("rstw", 40);
        tick();
        tick();
        tick();
        nReset = 1'b0;
        #1;
        chk("rstw_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rstw_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rstw_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rstw_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rstw_active", {31'd0, active}, 32'd0);
        chk("rstw_state", {30'd0, dut.state_r}, 32'd0);
        req_valid = 4'b0000;
        tick();
        nReset = 1'b1;
        tick();

        // Granted requester stalls mid-packet
        req_data = 32'h0022_1100;
        req_last = 4'b0100;
        req_valid = 4'b0110;
        wait_launch("stall1", 40);
        chk("stall1_gnt", {30'd0, grant_id}, 32'd1);
        chk("stall1_data", {24'd0, tx_data}, 32'h11);
        req_valid = 4'b0100;
        wait_launch("stall2", 40);
        chk("stall2_gnt", {30'd0, grant_id}, 32'd2);
        chk("stall2_data", {24'd0, tx_data}, 32'h22);
        req_valid = 4'b0000;
        wait_idle("stall", 40);

`ifdef UART_TX_ARB_PRIORITY_EN
        // Requester 0 jumps ahead of requester 3 at the next grant boundary
        do_reset();
        req_data = 32'h3FA0_000F;
        req_last = 4'b1001;
        req_valid = 4'b0100;
        wait_launch("prio1", 40);
        chk("prio1_gnt", {30'd0, grant_id}, 32'd2);
        req_data[23:16] = 8'hA1;
        req_last = 4'b1101;
        req_valid = 4'b1101;
        wait_launch("prio2", 40);
        chk("prio2_gnt", {30'd0, grant_id}, 32'd2);
        chk("prio2_data", {24'd0, tx_data}, 32'hA1);
        req_valid = 4'b1001;
        wait_launch("prio3", 40);
        chk("prio3_gnt", {30'd0, grant_id}, 32'd0);
        chk("prio3_data", {24'd0, tx_data}, 32'h0F);
        req_valid = 4'b1000;
        wait_launch("prio4", 40);
        chk("prio4_gnt", {30'd0, grant_id}, 32'd3);
        req_valid = 4'b0000;
        wait_idle("prio", 40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
